// File: rtl/periph_bus_initiator.sv
// Peripheral register bus initiator: command FIFO feeding a single-access FSM.
// Define PERIPH_INIT_RMW_EN to enable SET/CLR/TOGGLE read-modify-write commands.
module periph_bus_initiator #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        req_valid_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] data_i,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef PERIPH_INIT_RMW_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT,
    S_RMW_WR,
    S_RSP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT,
    S_RSP
  } state_t;
`endif

  logic        r_mem_we    [FIFO_DEPTH];
  logic [31:0] r_mem_addr  [FIFO_DEPTH];
  logic [31:0] r_mem_wdata [FIFO_DEPTH];
  logic [3:0]  r_mem_sel   [FIFO_DEPTH];
`ifdef PERIPH_INIT_RMW_EN
  logic [1:0]  r_mem_op    [FIFO_DEPTH];
`else
  logic        w_unused_op;
`endif

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [AW-1:0] w_widx;
  logic [AW-1:0] w_ridx;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_req_valid;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_sel;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;

  logic        w_req_nxt;
  logic        w_we_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_data_nxt;
  logic [3:0]  w_sel_nxt;
  logic        w_rspv_nxt;
  logic [31:0] w_rdata_nxt;

`ifdef PERIPH_INIT_RMW_EN
  logic [1:0]  r_op;
  logic [1:0]  w_op_nxt;
  logic        w_head_rmw;
  logic [31:0] w_new;
`endif

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (w_widx == w_ridx);
  assign w_push  = cmd_valid_i && !w_full;

  assign cmd_ready_o = !w_full;
  assign busy_o      = (r_state != S_IDLE) || !w_empty;
  assign req_valid_o = r_req_valid;
  assign we_o        = r_we;
  assign addr_o      = r_addr;
  assign data_o      = r_data;
  assign sel_o       = r_sel;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;

`ifdef PERIPH_INIT_RMW_EN
  assign w_head_rmw = r_mem_we[w_ridx] &&
                      (r_mem_op[w_ridx] != 2'b00);

  // r_data still holds the mask while the old value is read back
  always_comb begin
    w_new = data_i;
    unique case (r_op)
      2'b01:   w_new = data_i | r_data;
      2'b10:   w_new = data_i & ~r_data;
      2'b11:   w_new = data_i ^ r_data;
      default: w_new = data_i;
    endcase
  end
`else
  assign w_unused_op = ^cmd_op_i;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_we[w_widx]    <= cmd_we_i;
      r_mem_addr[w_widx]  <= cmd_addr_i;
      r_mem_wdata[w_widx] <= cmd_wdata_i;
      r_mem_sel[w_widx]   <= cmd_sel_i;
`ifdef PERIPH_INIT_RMW_EN
      r_mem_op[w_widx]    <= cmd_op_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_req_nxt   = 1'b0;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_sel_nxt   = r_sel;
    w_rspv_nxt  = r_rsp_valid;
    w_rdata_nxt = r_rsp_rdata;
`ifdef PERIPH_INIT_RMW_EN
    w_op_nxt    = r_op;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_mem_addr[w_ridx];
          w_data_nxt  = r_mem_wdata[w_ridx];
          w_sel_nxt   = r_mem_sel[w_ridx];
`ifdef PERIPH_INIT_RMW_EN
          w_we_nxt    = r_mem_we[w_ridx] && !w_head_rmw;
          w_op_nxt    = w_head_rmw ? r_mem_op[w_ridx] : 2'b00;
`else
          w_we_nxt    = r_mem_we[w_ridx];
`endif
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_rspv_nxt  = 1'b1;
          w_rdata_nxt = '0;
          w_state_nxt = S_RSP;
        end else begin
          w_state_nxt = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        w_rdata_nxt = data_i;
`ifdef PERIPH_INIT_RMW_EN
        if (r_op != 2'b00) begin
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_data_nxt  = w_new;
          w_state_nxt = S_RMW_WR;
        end else begin
          w_rspv_nxt  = 1'b1;
          w_state_nxt = S_RSP;
        end
`else
        w_rspv_nxt  = 1'b1;
        w_state_nxt = S_RSP;
`endif
      end
`ifdef PERIPH_INIT_RMW_EN
      S_RMW_WR: begin
        w_rspv_nxt  = 1'b1;
        w_state_nxt = S_RSP;
      end
`endif
      S_RSP: begin
        if (rsp_ready_i) begin
          w_rspv_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_valid <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef PERIPH_INIT_RMW_EN
      r_op        <= 2'b00;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_req_valid <= w_req_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_sel       <= w_sel_nxt;
      r_rsp_valid <= w_rspv_nxt;
      r_rsp_rdata <= w_rdata_nxt;
`ifdef PERIPH_INIT_RMW_EN
      r_op        <= w_op_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_periph_bus_initiator.sv
// Directed self-checking bench for periph_bus_initiator with a
// registered-read responder model.
module tb_periph_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [1:0]  cmd_op_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        req_valid_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [3:0]  sel_o;
  logic [31:0] data_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  logic [31:0] regs [0:15] = '{0: 32'h5, 3: 32'hF0, default: 32'h0};
  logic [31:0] rd_q = '0;

  always #5 clk = ~clk;

  periph_bus_initiator #(.FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i),
    .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .req_valid_o(req_valid_o),
    .we_o(we_o),
    .addr_o(addr_o),
    .data_o(data_o),
    .sel_o(sel_o),
    .data_i(data_i),
    .busy_o(busy_o)
  );

  // responder: byte-enabled writes, read data one cycle after the strobe
  assign data_i = rd_q;
  always @(posedge clk) begin
    if (req_valid_o) begin
      strobes++;
      if (we_o) begin
        for (int b = 0; b < 4; b++)
          if (sel_o[b])
            regs[addr_o[5:2]][8*b +: 8] <= data_o[8*b +: 8];
        rd_q <= '0;
      end else begin
        rd_q <= regs[addr_o[5:2]];
      end
    end else begin
      rd_q <= '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] sel);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    cmd_sel_i   = sel;
  endtask

  logic [31:0] exp5 [5];
  int s0;
  int got;
  int acc;

  initial begin
    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'b0;
    cmd_op_i = 2'b00;
    cmd_addr_i = '0;
    cmd_wdata_i = '0;
    cmd_sel_i = '0;
    rsp_ready_i = 1'b1;
    exp5 = '{32'h5, 32'h0, 32'hA1, 32'h0, 32'h1234};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req", req_valid_o, 1'b0);
    chk("rst_we", we_o, 1'b0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_sel", sel_o, 4'h0);
    chk("rst_rspv", rsp_valid_o, 1'b0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_ready", cmd_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // plain write latency
    s0 = strobes;
    drive(1'b1, 2'b00, 32'h4, 32'h3, 4'hF);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("wr_e0_req", req_valid_o, 1'b0);
    chk("wr_e0_busy", busy_o, 1'b1);
    @(negedge clk);
    chk("wr_e1_req", req_valid_o, 1'b1);
    chk("wr_e1_we", we_o, 1'b1);
    chk("wr_e1_addr", addr_o, 32'h4);
    chk("wr_e1_data", data_o, 32'h3);
    chk("wr_e1_sel", sel_o, 4'hF);
    chk("wr_e1_rspv", rsp_valid_o, 1'b0);
    @(negedge clk);
    chk("wr_e2_rspv", rsp_valid_o, 1'b1);
    chk("wr_e2_rdata", rsp_rdata_o, 32'h0);
    chk("wr_e2_req", req_valid_o, 1'b0);
    @(negedge clk);
    chk("wr_done_rspv", rsp_valid_o, 1'b0);
    chk("wr_done_busy", busy_o, 1'b0);
    chk("wr_strobes", strobes - s0, 1);
    chk("wr_reg", regs[1], 32'h3);

    // plain read latency
    s0 = strobes;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("rd_e1_req", req_valid_o, 1'b1);
    chk("rd_e1_we", we_o, 1'b0);
    chk("rd_e1_addr", addr_o, 32'h0);
    @(negedge clk);
    chk("rd_e2_rspv", rsp_valid_o, 1'b0);
    chk("rd_e2_req", req_valid_o, 1'b0);
    @(negedge clk);
    chk("rd_e3_rspv", rsp_valid_o, 1'b1);
    chk("rd_e3_rdata", rsp_rdata_o, 32'h5);
    @(negedge clk);
    chk("rd_done_rspv", rsp_valid_o, 1'b0);
    chk("rd_strobes", strobes - s0, 1);

    // backpressure: 5 accepted, 6th refused
    rsp_ready_i = 1'b0;
    s0 = strobes;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1'b0, 2'b00, 32'h0, 32'h0, 4'hF);
        1: drive(1'b1, 2'b00, 32'h8, 32'hA1, 4'hF);
        2: drive(1'b0, 2'b00, 32'h8, 32'h0, 4'hF);
        3: drive(1'b1, 2'b00, 32'h4, 32'h1234, 4'h3);
        4: drive(1'b0, 2'b00, 32'h4, 32'h0, 4'hF);
        default: drive(1'b1, 2'b00, 32'h3C, 32'hDEAD, 4'hF);
      endcase
      chk($sformatf("bp_ready%0d", i), cmd_ready_o, (i < 5) ? 1'b1 : 1'b0);
      if (cmd_ready_o)
        acc++;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    chk("bp_accepted", acc, 5);
    repeat (3) begin
      chk("bp_hold_rspv", rsp_valid_o, 1'b1);
      chk("bp_hold_rdata", rsp_rdata_o, 32'h5);
      @(negedge clk);
    end
    chk("bp_full", cmd_ready_o, 1'b0);
    rsp_ready_i = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
      if (rsp_valid_o) begin
        chk($sformatf("bp_rsp%0d", got), rsp_rdata_o, exp5[got]);
        got++;
      end
      @(negedge clk);
    end
    chk("bp_rsp_count", got, 5);
    repeat (2) @(negedge clk);
    chk("bp_strobes", strobes - s0, 5);
    chk("bp_idle_busy", busy_o, 1'b0);

`ifdef PERIPH_INIT_RMW_EN
    // SET 0x0F on 0xF0
    s0 = strobes;
    drive(1'b1, 2'b01, 32'hC, 32'h0F, 4'hF);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("set_rd_req", req_valid_o, 1'b1);
    chk("set_rd_we", we_o, 1'b0);
    @(negedge clk);
    chk("set_e2_req", req_valid_o, 1'b0);
    @(negedge clk);
    chk("set_wr_req", req_valid_o, 1'b1);
    chk("set_wr_we", we_o, 1'b1);
    chk("set_wr_data", data_o, 32'hFF);
    chk("set_wr_addr", addr_o, 32'hC);
    chk("set_e3_rspv", rsp_valid_o, 1'b0);
    @(negedge clk);
    chk("set_e4_rspv", rsp_valid_o, 1'b1);
    chk("set_rdata", rsp_rdata_o, 32'hF0);
    chk("set_e4_req", req_valid_o, 1'b0);
    @(negedge clk);
    chk("set_strobes", strobes - s0, 2);
    // CLR 0xF0 on 0xFF
    drive(1'b1, 2'b10, 32'hC, 32'hF0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_wr_req", req_valid_o, 1'b1);
    chk("clr_wr_data", data_o, 32'h0F);
    @(negedge clk);
    chk("clr_rdata", rsp_rdata_o, 32'hFF);
    @(negedge clk);
`else
    // SET op is ignored: plain write
    s0 = strobes;
    drive(1'b1, 2'b01, 32'hC, 32'h0F, 4'hF);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("set_plain_req", req_valid_o, 1'b1);
    chk("set_plain_we", we_o, 1'b1);
    chk("set_plain_data", data_o, 32'h0F);
    @(negedge clk);
    chk("set_plain_rspv", rsp_valid_o, 1'b1);
    chk("set_plain_rdata", rsp_rdata_o, 32'h0);
    @(negedge clk);
    chk("set_plain_strobes", strobes - s0, 1);
`endif

    // reset during RDWAIT with two commands queued
    drive(1'b0, 2'b00, 32'h0, 32'h0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 2'b00, 32'h20, 32'h1, 4'hF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 2'b00, 32'h24, 32'h2, 4'hF);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("mid_busy", busy_o, 1'b1);
    s0 = strobes;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", req_valid_o, 1'b0);
    chk("mid_rst_we", we_o, 1'b0);
    chk("mid_rst_addr", addr_o, 32'h0);
    chk("mid_rst_data", data_o, 32'h0);
    chk("mid_rst_sel", sel_o, 4'h0);
    chk("mid_rst_rspv", rsp_valid_o, 1'b0);
    chk("mid_rst_rdata", rsp_rdata_o, 32'h0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_ready", cmd_ready_o, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_strobes", strobes - s0, 0);
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_rspv", rsp_valid_o, 1'b0);

    drive(1'b1, 2'b00, 32'h10, 32'h55, 4'hF);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("post_e0_req", req_valid_o, 1'b0);
    @(negedge clk);
    chk("post_e1_req", req_valid_o, 1'b1);
    chk("post_e1_addr", addr_o, 32'h10);
    chk("post_e1_data", data_o, 32'h55);
    @(negedge clk);
    chk("post_e2_rspv", rsp_valid_o, 1'b1);
    chk("post_e2_rdata", rsp_rdata_o, 32'h0);
    @(negedge clk);
    chk("post_strobes", strobes - s0, 1);
    chk("post_reg", regs[4], 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_bus_initiator.md
Name: periph_bus_initiator

Overview:
- Bus initiator for the peripheral register bus. It issues single-beat reads and writes to responders such as gpio, timer and uart.
- A core- or debug-side command stream with valid/ready handshake feeds a small command FIFO.
- An FSM drives one access at a time on the peripheral bus, collects the registered read data and returns an in-order response stream.
- Peripheral-bus protocol: the responder samples addr/data/sel/we in any cycle where req_valid is high. Writes take effect at the end of that cycle. Read data is registered and valid exactly one cycle later; the responder drives zero otherwise.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid_i  input  1  command offered.
- cmd_ready_o  output  1  FIFO can accept a command (= !full).
- cmd_we_i  input  1  1 = write, 0 = read.
- cmd_op_i  input  2  00 plain; 01 SET, 10 CLR, 11 TOGGLE (RMW only).
- cmd_addr_i  input  32  target address.
- cmd_wdata_i  input  32  write data / RMW mask.
- cmd_sel_i  input  4  byte enables.
- rsp_valid_o  output  1  response available.
- rsp_ready_i  input  1  response consumed.
- rsp_rdata_o  output  32  read data; 0 for plain writes.
- req_valid_o  output  1  peripheral access strobe.
- we_o  output  1  peripheral write enable.
- addr_o  output  32  peripheral address.
- data_o  output  32  peripheral write data.
- sel_o  output  4  peripheral byte enables.
- data_i  input  32  peripheral read data, valid 1 cycle after a read strobe.
- busy_o  output  1  FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset values: req_valid_o, we_o, addr_o, data_o, sel_o, rsp_valid_o and rsp_rdata_o are 0. FIFO is emptied, FSM is in IDLE, cmd_ready_o=1, busy_o=0.
- Reset mid-operation abandons any in-flight access and all queued commands. req_valid_o drops immediately on reset assertion.
- FIFO:
  - Push on cmd_valid_i & cmd_ready_o.
  - Pop only when the FSM is in IDLE and the FIFO is non-empty.
  - When full, cmd_ready_o=0, so there is no push-through.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop and register the command into addr_o/data_o/sel_o/we_o, set req_valid_o, and go to ISSUE.
  - ISSUE (req_valid_o=1 for exactly this one cycle): for a write go to RSP with rsp_rdata_o=0; for a read or RMW go to RDWAIT. Clear req_valid_o on exit.
  - RDWAIT: capture data_i at the cycle end.
    - Plain read: set rsp_rdata_o=data_i and go to RSP.
    - RMW: go to RMW_WR.
  - RMW_WR: one-cycle write strobe with the new value, same addr and sel. Then go to RSP with rsp_rdata_o = old value.
  - RSP: rsp_valid_o=1. rsp_rdata_o is held stable until rsp_ready_i. On handshake, clear rsp_valid_o and go to IDLE; the next pop happens no earlier than the following cycle.
- Latency from the push edge E0:
  - req_valid_o is high during the cycle after edge E1.
  - Write: rsp_valid_o rises after E2.
  - Read: rsp_valid_o rises after E3.
  - RMW: rsp_valid_o rises after E4.
- addr_o, data_o, sel_o and we_o hold their last values while req_valid_o=0.
- Responses are strictly in command order. At most one access is outstanding.
- Capacity with rsp_ready_i held low is FIFO_DEPTH + 1 commands: FIFO_DEPTH queued plus one parked in RSP.

Optional Feature:
- Macro PERIPH_INIT_RMW_EN.
- Defined: a write command with cmd_op_i != 00 performs a read-modify-write. With mask = cmd_wdata_i and old = the read value, new is old|mask for SET, old&~mask for CLR, old^mask for TOGGLE. rsp_rdata_o returns old.
- Not defined: cmd_op_i is ignored and every command is plain. The RMW_WR state is absent.

Test Plan:
- Push write addr=0x4, wdata=0x3, sel=0xF, rsp_ready=1 -> the responder model sees one strobe cycle after E1 with we_o=1, addr_o=0x4, data_o=0x3, sel_o=0xF; rsp_valid_o after E2 with rsp_rdata_o=0.
- Push read addr=0x0 with the model returning 0x0000_0005 -> single strobe with we_o=0; rsp_valid_o after E3 with rsp_rdata_o=0x5.
- Hold rsp_ready=0 and push 6 commands back-to-back (FIFO_DEPTH=4) -> 5 accepted, cmd_ready_o=0 on the 6th; rsp_valid_o and rsp_rdata_o stay stable. Release ready -> 5 in-order responses, one strobe each.
- With RMW enabled: model register=0x0000_00F0, push SET mask 0x0F -> read strobe, then write strobe with data_o=0xFF, rsp_rdata_o=0xF0. Then CLR mask 0xF0 -> write data_o=0x0F.
- With RMW disabled, the same SET command -> one plain write with data_o=0x0F, rsp_rdata_o=0.
- Assert rst_n low during RDWAIT with 2 commands queued -> all outputs 0, busy_o=0, no further strobes. After release, a new write issues with the nominal latency.
